data_mem_responder: RTL and testbench

//  Word-addressed data memory that answers the CPU's MEM-stage load/store requests.
//  It replaces the zero-latency dm with a request/ack responder that has a fixed

---
 rtl/data_mem_responder.sv | 78 +++++++
 tb/tb_data_mem_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency request/ack data memory; define MISALIGN_CHECK_EN to flag and suppress misaligned accesses
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t          state, state_n;
  logic [3:0]      cnt;
  logic            wr_q, mis_q, mis_in;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH];
  logic            cur_wr, cur_mis, enter_ack;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic            unused_addr;
`ifdef MISALIGN_CHECK_EN
  assign mis_in = |addr_i[1:0];
`else
  assign mis_in = 1'b0;
`endif
  assign unused_addr = ^addr_i;
  assign stall_o     = req_i & ~ack_o;
  assign enter_ack   = state != ACK && state_n == ACK;
  // with LATENCY 1 the ACK edge is the accept edge, so live inputs stand in for the latched copies
  assign cur_wr      = state == IDLE ? wr_i : wr_q;
  assign cur_mis     = state == IDLE ? mis_in : mis_q;
  assign cur_idx     = state == IDLE ? addr_i[AW+1:2] : idx_q;
  assign cur_wdata   = state == IDLE ? wdata_i : wdata_q;
  // next-state: accept in IDLE, count down in BUSY, single ACK cycle
  always_comb begin
    state_n = state == ACK  ? IDLE :
              state == BUSY ? (cnt == 4'd1 ? ACK : BUSY) :
              !req_i        ? IDLE :
              LATENCY == 1  ? ACK : BUSY;
  end
  // state, countdown and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= state == IDLE && req_i ? 4'(LATENCY - 1) : state == BUSY ? cnt - 4'd1 : cnt;
      ack_o   <= enter_ack;
      err_o   <= enter_ack && cur_mis;
      if (enter_ack && !cur_wr && !cur_mis) rdata_o <= mem[cur_idx];
    end
  end
  // request capture at accept
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req_i) begin
      wr_q    <= wr_i;
      mis_q   <= mis_in;
      idx_q   <= addr_i[AW+1:2];
      wdata_q <= wdata_i;
    end
  end
  // store commits on the edge entering ACK; reset on that edge discards it
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_ack && cur_wr && !cur_mis) mem[cur_idx] <= cur_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of two responders (LATENCY 3 and 1) against a word-array model
module tb_data_mem_responder;
  logic        clk;
  logic        rst   [2];
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];
  logic [31:0] mem_m [2][256];
  logic [31:0] rd_m  [2];
  int tests = 0;
  int fails = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .wr_i(wr[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0]));
  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .wr_i(wr[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
    end
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd, input bit keep);
    int lat = d == 0 ? 3 : 1;
    int idx = int'(a[9:2]);
    bit mis = 0;
    bit exp_err;
`ifdef MISALIGN_CHECK_EN
    mis = a[1:0] != 2'b00;
`endif
    exp_err = mis;
    if (!mis && w) mem_m[d][idx] = wd;
    if (!mis && !w) rd_m[d] = mem_m[d][idx];
    @(posedge clk); @(negedge clk);
    chk("idle_ack", d, 32'(ack[d]), 0);
    chk("idle_stall", d, 32'(stall[d]), 32'(req[d]));
    req[d] = 1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    #1;
    chk("accept_stall", d, 32'(stall[d]), 1);
    chk("accept_ack", d, 32'(ack[d]), 0);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); @(negedge clk);
      wr[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
      #1;
      chk("busy_stall", d, 32'(stall[d]), 1);
      chk("busy_ack", d, 32'(ack[d]), 0);
    end
    @(posedge clk); @(negedge clk);
    chk("ack", d, 32'(ack[d]), 1);
    chk("ack_stall", d, 32'(stall[d]), 0);
    chk("err", d, 32'(err[d]), 32'(exp_err));
    chk("rdata", d, rdata[d], rd_m[d]);
    if (!keep) req[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; req[d] = 0; wr[d] = 0; addr[d] = 0; wdata[d] = 0; rd_m[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", d, 32'(ack[d]), 0);
      chk("rst_stall", d, 32'(stall[d]), 0);
      chk("rst_rdata", d, rdata[d], 0);
      chk("rst_err", d, 32'(err[d]), 0);
    end
    txn(0, 1, 32'h10, 32'hDEADBEEF, 0);
    txn(0, 0, 32'h10, 32'h0, 0);
    chk("deadbeef", 0, rdata[0], 32'hDEADBEEF);
    txn(0, 1, 32'h400, 32'h00001234, 0);
    txn(0, 0, 32'h000, 32'h0, 0);
    chk("alias", 0, rdata[0], 32'h00001234);
    txn(1, 1, 32'h8, 32'h55, 1);
    txn(1, 0, 32'h8, 32'h0, 1);
    txn(1, 1, 32'h8, 32'h55, 1);
    txn(1, 0, 32'h8, 32'h0, 0);
    chk("lat1_load", 1, rdata[1], 32'h55);
    txn(0, 1, 32'h10, 32'h77, 0);
    txn(0, 0, 32'h13, 32'h0, 0);
`ifdef MISALIGN_CHECK_EN
    chk("misalign_rdata", 0, rdata[0], 32'h00001234);
`else
    chk("misalign_rdata", 0, rdata[0], 32'h77);
`endif
    txn(0, 1, 32'h20, 32'h0, 0);
    @(posedge clk); @(negedge clk);
    req[0] = 1; wr[0] = 1; addr[0] = 32'h20; wdata[0] = 32'hA5A5;
    @(posedge clk); @(negedge clk);
    rst[0] = 1;
    @(posedge clk); @(negedge clk);
    rst[0] = 0; req[0] = 0; rd_m[0] = 0;
    #1;
    chk("midrst_rdata", 0, rdata[0], 0);
    chk("midrst_stall", 0, 32'(stall[0]), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("midrst_noack", 0, 32'(ack[0]), 0);
    end
    txn(0, 0, 32'h20, 32'h0, 0);
    chk("midrst_load", 0, rdata[0], 32'h0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) txn(d, 1, 32'(i * 4), $urandom, 0);
    for (int d = 0; d < 2; d++)
      repeat (150) txn(d, 1'($urandom), $urandom, $urandom, 1'($urandom));
    @(posedge clk); @(negedge clk);
    req[0] = 0; req[1] = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
